// File: rtl/coin_credit_fsm.sv
`default_nettype none
// ============================================================================
// Module   : coin_credit_fsm
// Purpose  : Coin acceptor and vend controller. Each coin insertion is counted
//            exactly once, however long it is held. Credit accumulates, and a
//            drop pulse fires when credit reaches PRICE, with the remainder
//            carried forward. A refund request returns unused credit. A
//            saturating counter records the number of vends.
// Revision : 1.0 - initial release
// ============================================================================
module coin_credit_fsm #(
    parameter int CREDIT_W  = 4,
    parameter int PRICE     = 4,
    parameter int COIN1_VAL = 1,
    parameter int COIN2_VAL = 2,
    parameter int COIN3_VAL = 3,
    parameter int COUNT_W   = 8
) (
    input  logic                clock,
    input  logic                reset_N,
    input  logic [1:0]          coin_i,
    input  logic                refund_i,
    output logic                drop_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                change_valid_o,
    output logic [CREDIT_W-1:0] change_amt_o,
    output logic [COUNT_W-1:0]  vend_count_o,
    output logic                busy_o
);

    // ------------------------------------------------------------------------
    // Parameter legality. Keeping every coin value within 1..PRICE means one
    // coin can never push credit past 2*PRICE-1. That allows at most one drop
    // per coin, and the CREDIT_W+1 bit sum cannot overflow.
    // ------------------------------------------------------------------------
    generate
        if (PRICE < 1 || PRICE > (2**CREDIT_W) - 1) begin : g_bad_price
            $error("coin_credit_fsm: PRICE out of range 1..2**CREDIT_W-1");
        end
        if (COIN1_VAL < 1 || COIN1_VAL > PRICE) begin : g_bad_coin1
            $error("coin_credit_fsm: COIN1_VAL out of range 1..PRICE");
        end
        if (COIN2_VAL < 1 || COIN2_VAL > PRICE) begin : g_bad_coin2
            $error("coin_credit_fsm: COIN2_VAL out of range 1..PRICE");
        end
        if (COIN3_VAL < 1 || COIN3_VAL > PRICE) begin : g_bad_coin3
            $error("coin_credit_fsm: COIN3_VAL out of range 1..PRICE");
        end
    endgenerate

    // Arithmetic is done one bit wider than credit, so credit + coin is exact.
    localparam logic [CREDIT_W:0] C_PRICE = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0] C_VAL1  = (CREDIT_W+1)'(COIN1_VAL);
    localparam logic [CREDIT_W:0] C_VAL2  = (CREDIT_W+1)'(COIN2_VAL);
    localparam logic [CREDIT_W:0] C_VAL3  = (CREDIT_W+1)'(COIN3_VAL);
    localparam logic [COUNT_W-1:0] C_COUNT_MAX = {COUNT_W{1'b1}};

    // IDLE waits for a coin. HOLD locks the coin bus until it returns to 00.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                state_q,        state_d;
    logic [CREDIT_W-1:0]   credit_q,       credit_d;
    logic                  drop_q,         drop_d;
    logic                  change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0]   change_amt_q,   change_amt_d;
    logic [COUNT_W-1:0]    vend_count_q,   vend_count_d;

    logic [CREDIT_W:0]     coin_val;
    logic [CREDIT_W:0]     sum;

    // Decode the coin code into its configured value. Code 00 decodes to zero.
    always_comb begin
        coin_val = '0;
        case (coin_i)
            2'b01:   coin_val = C_VAL1;
            2'b10:   coin_val = C_VAL2;
            2'b11:   coin_val = C_VAL3;
            default: coin_val = '0;
        endcase
    end

    assign sum = {1'b0, credit_q} + coin_val;

    // Next-state and output logic. The pulses default low, and registers
    // without pulse behaviour default to holding their value.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        drop_d         = 1'b0;
        change_valid_d = 1'b0;
        change_amt_d   = change_amt_q;
        vend_count_d   = vend_count_q;

        case (state_q)
            S_IDLE: begin
                if (coin_i != 2'b00) begin
                    // A coin wins over refund in the same cycle.
                    state_d = S_HOLD;
                    if (sum >= C_PRICE) begin
                        credit_d = CREDIT_W'(sum - C_PRICE);
                        drop_d   = 1'b1;
                        if (vend_count_q != C_COUNT_MAX) begin
                            vend_count_d = vend_count_q + COUNT_W'(1);
                        end
                    end else begin
                        credit_d = CREDIT_W'(sum);
                    end
                end else if (refund_i && (credit_q != '0)) begin
                    // Clearing credit here also stops a held refund from
                    // pulsing twice.
                    change_amt_d   = credit_q;
                    change_valid_d = 1'b1;
                    credit_d       = '0;
                end
            end
            S_HOLD: begin
                // Both the code value and refund are ignored until the bus
                // returns to 00.
                if (coin_i == 2'b00) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset is asynchronous and clears all of them.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            drop_q         <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            vend_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            drop_q         <= drop_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            vend_count_q   <= vend_count_d;
        end
    end

    assign drop_o         = drop_q;
    assign credit_o       = credit_q;
    assign change_valid_o = change_valid_q;
    assign change_amt_o   = change_amt_q;
    assign vend_count_o   = vend_count_q;
    assign busy_o         = (state_q == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_coin_credit_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_credit_fsm
// Purpose  : Self-checking bench for coin_credit_fsm. It drives two instances
//            with the same stimulus: one at default widths and one with
//            COUNT_W=2 to exercise vend-count saturation. Outputs are compared
//            against a behavioural credit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_credit_fsm;

    localparam int PRICE = 4;
    localparam int V1 = 1, V2 = 2, V3 = 3;

    logic       clock;
    logic       reset_N;
    logic [1:0] coin;
    logic       refund;

    logic       drop_a, cv_a, busy_a;
    logic [3:0] credit_a, amt_a;
    logic [7:0] vc_a;
    logic       drop_b, cv_b, busy_b;
    logic [3:0] credit_b, amt_b;
    logic [1:0] vc_b;

    coin_credit_fsm #(.CREDIT_W(4), .PRICE(PRICE), .COIN1_VAL(V1), .COIN2_VAL(V2),
                      .COIN3_VAL(V3), .COUNT_W(8)) dut_a (
        .clock(clock), .reset_N(reset_N), .coin_i(coin), .refund_i(refund),
        .drop_o(drop_a), .credit_o(credit_a), .change_valid_o(cv_a),
        .change_amt_o(amt_a), .vend_count_o(vc_a), .busy_o(busy_a));

    coin_credit_fsm #(.CREDIT_W(4), .PRICE(PRICE), .COIN1_VAL(V1), .COIN2_VAL(V2),
                      .COIN3_VAL(V3), .COUNT_W(2)) dut_b (
        .clock(clock), .reset_N(reset_N), .coin_i(coin), .refund_i(refund),
        .drop_o(drop_b), .credit_o(credit_b), .change_valid_o(cv_b),
        .change_amt_o(amt_b), .vend_count_o(vc_b), .busy_o(busy_b));

    // Every observable output of both instances, concatenated in one bus.
    wire logic [31:0] act = {busy_a, drop_a, cv_a, amt_a, credit_a, vc_a, vc_b,
                             busy_b, drop_b, cv_b, amt_b, credit_b};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: credit as a plain integer, a "coin being held" flag,
    // and a total vend tally that is clipped to each counter width on compare.
    int m_credit, m_amt, m_vends;
    bit m_hold, m_drop, m_cv;

    function automatic int coin_value(input logic [1:0] c);
        case (c)
            2'b01:   return V1;
            2'b10:   return V2;
            2'b11:   return V3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] exp_bus();
        int va, vb;
        va = (m_vends > 255) ? 255 : m_vends;
        vb = (m_vends > 3) ? 3 : m_vends;
        return {m_hold, m_drop, m_cv, 4'(m_amt), 4'(m_credit), 8'(va), 2'(vb),
                m_hold, m_drop, m_cv, 4'(m_amt), 4'(m_credit)};
    endfunction

    task automatic model_reset();
        m_credit = 0; m_amt = 0; m_vends = 0;
        m_hold = 0; m_drop = 0; m_cv = 0;
    endtask

    // Advance one clock edge, apply the vending rules to the model, and leave
    // time 1 unit past the edge so outputs are sampled away from it.
    task automatic tick();
        @(posedge clock);
        if (!reset_N) begin
            model_reset();
        end else begin
            m_drop = 0;
            m_cv   = 0;
            if (!m_hold) begin
                if (coin != 2'b00) begin
                    m_hold   = 1;
                    m_credit = m_credit + coin_value(coin);
                    if (m_credit >= PRICE) begin
                        m_credit = m_credit - PRICE;
                        m_drop   = 1;
                        m_vends  = m_vends + 1;
                    end
                end else if (refund && m_credit != 0) begin
                    m_amt    = m_credit;
                    m_cv     = 1;
                    m_credit = 0;
                end
            end else if (coin == 2'b00) begin
                m_hold = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_N = 1'b0; coin = 2'b11; refund = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (act !== exp_bus()) begin
                n_err++; $display("FAIL reset_hold: got %h want %h", act, exp_bus());
            end
        end
        n_vec++;
        if (credit_a !== 4'd0 || drop_a !== 1'b0 || busy_a !== 1'b0) begin
            n_err++; $display("FAIL reset_zero: credit %0d drop %b busy %b want 0 0 0", credit_a, drop_a, busy_a);
        end
        reset_N = 1'b1;
        tick();
        n_vec++;
        if (credit_a !== 4'd3 || busy_a !== 1'b1 || act !== exp_bus()) begin
            n_err++; $display("FAIL reset_release: credit %0d busy %b want 3 1 (bus %h want %h)", credit_a, busy_a, act, exp_bus());
        end
    endtask

    task automatic test_hold_no_repeat();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (act !== exp_bus() || credit_a !== 4'd3) begin
                n_err++; $display("FAIL hold_repeat: got %h want %h", act, exp_bus());
            end
        end
        coin = 2'b00; tick();
        coin = 2'b10; tick();
        n_vec++;
        if (credit_a !== 4'd1 || drop_a !== 1'b1 || vc_a !== 8'd1 || act !== exp_bus()) begin
            n_err++; $display("FAIL hold_vend: credit %0d drop %b count %0d want 1 1 1", credit_a, drop_a, vc_a);
        end
        coin = 2'b00; tick();
        n_vec++;
        if (drop_a !== 1'b0 || act !== exp_bus()) begin
            n_err++; $display("FAIL drop_width: drop %b want 0", drop_a);
        end
    endtask

    task automatic test_coin1_seq();
        refund = 1'b1; tick();
        refund = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            coin = 2'b01; tick();
            n_vec++;
            if (act !== exp_bus()) begin
                n_err++; $display("FAIL coin1_seq[%0d]: got %h want %h", i, act, exp_bus());
            end
            coin = 2'b00; tick();
        end
        n_vec++;
        if (credit_a !== 4'd0 || vc_a !== 8'd2) begin
            n_err++; $display("FAIL coin1_total: credit %0d count %0d want 0 2", credit_a, vc_a);
        end
        coin = 2'b01; tick();
        coin = 2'b10; tick(); tick();
        coin = 2'b00; tick();
        n_vec++;
        if (credit_a !== 4'd1 || act !== exp_bus()) begin
            n_err++; $display("FAIL code_change: credit %0d want 1", credit_a);
        end
    endtask

    task automatic test_refund();
        int pulses;
        coin = 2'b10; tick();
        coin = 2'b00; tick();
        pulses = 0;
        refund = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(cv_a);
            n_vec++;
            if (act !== exp_bus()) begin
                n_err++; $display("FAIL refund_cycle[%0d]: got %h want %h", i, act, exp_bus());
            end
        end
        n_vec++;
        if (pulses !== 1 || amt_a !== 4'd3 || credit_a !== 4'd0) begin
            n_err++; $display("FAIL refund_once: pulses %0d amt %0d credit %0d want 1 3 0", pulses, amt_a, credit_a);
        end
        tick();
        n_vec++;
        if (cv_a !== 1'b0 || act !== exp_bus()) begin
            n_err++; $display("FAIL refund_empty: change_valid %b want 0", cv_a);
        end
        refund = 1'b0;
    endtask

    task automatic test_simultaneous();
        coin = 2'b01; tick();
        coin = 2'b00; tick();
        coin = 2'b10; refund = 1'b1; tick();
        n_vec++;
        if (credit_a !== 4'd3 || cv_a !== 1'b0 || act !== exp_bus()) begin
            n_err++; $display("FAIL coin_vs_refund: credit %0d cv %b want 3 0", credit_a, cv_a);
        end
        coin = 2'b00; tick(); tick();
        n_vec++;
        if (amt_a !== 4'd3 || credit_a !== 4'd0 || act !== exp_bus()) begin
            n_err++; $display("FAIL late_refund: amt %0d credit %0d want 3 0", amt_a, credit_a);
        end
        refund = 1'b0; tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            coin = 2'b11; tick();
            coin = 2'b00; tick();
            coin = 2'b01; tick();
            n_vec++;
            if (act !== exp_bus() || drop_a !== 1'b1) begin
                n_err++; $display("FAIL sat_vend[%0d]: got %h want %h", i, act, exp_bus());
            end
            coin = 2'b00; tick();
        end
        n_vec++;
        if (vc_b !== 2'd3) begin
            n_err++; $display("FAIL sat_count: count %0d want 3", vc_b);
        end
    endtask

    task automatic test_async_reset();
        coin = 2'b11; tick();
        coin = 2'b00; tick();
        coin = 2'b01; tick();
        #3 reset_N = 1'b0;
        #1 model_reset();
        n_vec++;
        if (act !== 32'h0 || act !== exp_bus()) begin
            n_err++; $display("FAIL async_clear: got %h want %h", act, exp_bus());
        end
        tick();
        reset_N = 1'b1;
        tick();
        n_vec++;
        if (credit_a !== 4'd1 || busy_a !== 1'b1 || act !== exp_bus()) begin
            n_err++; $display("FAIL post_reset_coin: credit %0d busy %b want 1 1", credit_a, busy_a);
        end
        coin = 2'b00; tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) coin = 2'($urandom_range(0, 3));
            refund = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) begin
                reset_N = 1'b0;
                #1 model_reset();
                n_vec++;
                if (act !== exp_bus()) begin
                    n_err++; $display("FAIL rand_reset[%0d]: got %h want %h", i, act, exp_bus());
                end
                tick();
                reset_N = 1'b1;
            end
            tick();
            n_vec++;
            if (act !== exp_bus()) begin
                n_err++; $display("FAIL rand[%0d]: got %h want %h", i, act, exp_bus());
            end
        end
    endtask

    initial begin
        reset_N = 1'b0; coin = 2'b00; refund = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_hold_no_repeat();
        test_coin1_seq();
        test_refund();
        test_simultaneous();
        test_saturation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
